// File: rtl/sr_latch_driver.sv
// Pulse driver for an external SR latch: issues a timed set/reset pulse per
// command, then checks latch feedback and raises a sticky error on mismatch.
module sr_latch_driver #(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic req_val,
  input  logic q_fb,
  input  logic q_bar_fb,
  output logic s,
  output logic r,
  output logic busy,
  output logic done,
  output logic err,
  output logic level
);

  typedef enum logic [1:0] {IDLE, PULSE, CHECK, GAP} state_t;

  localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD   = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_level, w_level_nxt;
  logic       r_err, w_err_nxt;
  logic       r_s, r_r, r_done;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_err_nxt   = r_err;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_level_nxt = req_val;
          w_cnt_nxt   = PULSE_LOAD;
          w_state_nxt = PULSE;
        end
      end
      PULSE: begin
        if (r_cnt == 4'd0) w_state_nxt = CHECK;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      CHECK: begin
        if ((q_fb != r_level) || (q_bar_fb != ~r_level)) w_err_nxt = 1'b1;
        if (GAP_CYCLES > 0) begin
          w_cnt_nxt   = GAP_LOAD;
          w_state_nxt = GAP;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GAP: begin
        if (r_cnt == 4'd0) w_state_nxt = IDLE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // s/r/done are registered from the next state so they line up with the state
  // they belong to; s and r derive from one level bit, so they are exclusive.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_err   <= 1'b0;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_err   <= w_err_nxt;
      r_s     <= (w_state_nxt == PULSE) &  w_level_nxt;
      r_r     <= (w_state_nxt == PULSE) & ~w_level_nxt;
      r_done  <= (w_state_nxt == CHECK);
    end
  end

  assign s     = r_s;
  assign r     = r_r;
  assign busy  = (r_state != IDLE);
  assign done  = r_done;
  assign err   = r_err;
  assign level = r_level;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench: stimulus pushes expected command results, monitors pop and
// compare on each done pulse. Second instance exercises P=1, G=0.
module tb_sr_latch_driver;

  localparam int unsigned P0 = 2;
  localparam int unsigned G0 = 1;

  typedef struct {
    logic        val;
    int unsigned dcyc;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic req, req_val, q_fb, q_bar_fb;
  logic s, r, busy, done, err, level;
  logic req1, req_val1, q_fb1, q_bar_fb1;
  logic s1, r1, busy1, done1, err1, level1;

  int unsigned cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic exp_err = 1'b0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sr_latch_driver #(.PULSE_CYCLES(P0), .GAP_CYCLES(G0)) dut (
    .clk(clk), .reset(reset), .req(req), .req_val(req_val), .q_fb(q_fb),
    .q_bar_fb(q_bar_fb), .s(s), .r(r), .busy(busy), .done(done), .err(err),
    .level(level)
  );

  sr_latch_driver #(.PULSE_CYCLES(1), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .req_val(req_val1), .q_fb(q_fb1),
    .q_bar_fb(q_bar_fb1), .s(s1), .r(r1), .busy(busy1), .done(done1), .err(err1),
    .level(level1)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor for the default instance
  int unsigned sc0 = 0, rc0 = 0;
  bit   pend0 = 0;
  logic perr0;
  always @(negedge clk) begin
    exp_t e;
    chk("s_r_exclusive", {31'd0, s & r}, 0);
    if (pend0) begin
      chk("err_after_check", {31'd0, err}, {31'd0, perr0});
      pend0 = 0;
    end
    if (s) sc0++;
    if (r) rc0++;
    if (done) begin
      if (q0.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = q0.pop_front();
        chk("done_cycle", cyc, e.dcyc);
        chk("level_at_done", {31'd0, level}, {31'd0, e.val});
        chk("s_pulse_len", sc0, e.val ? P0 : 0);
        chk("r_pulse_len", rc0, e.val ? 0 : P0);
        pend0 = 1;
        perr0 = e.err;
      end
      sc0 = 0;
      rc0 = 0;
    end
    if (reset) begin
      sc0 = 0;
      rc0 = 0;
      pend0 = 0;
    end
  end

  // Monitor for the P=1, G=0 instance
  int unsigned sc1 = 0, rc1 = 0;
  always @(negedge clk) begin
    exp_t e;
    chk("s1_r1_exclusive", {31'd0, s1 & r1}, 0);
    if (s1) sc1++;
    if (r1) rc1++;
    if (done1) begin
      if (q1.size() == 0) begin
        chk("unexpected_done1", 1, 0);
      end else begin
        e = q1.pop_front();
        chk("done1_cycle", cyc, e.dcyc);
        chk("level1_at_done", {31'd0, level1}, {31'd0, e.val});
        chk("s1_pulse_len", sc1, e.val ? 1 : 0);
        chk("r1_pulse_len", rc1, e.val ? 0 : 1);
        chk("err1", {31'd0, err1}, {31'd0, e.err});
      end
      sc1 = 0;
      rc1 = 0;
    end
    if (reset) begin
      sc1 = 0;
      rc1 = 0;
    end
  end

  task automatic run_cmd(input logic v, input logic qf, input logic qbf, input bit poke);
    @(negedge clk);
    #1;
    q_fb = qf;
    q_bar_fb = qbf;
    req = 1'b1;
    req_val = v;
    exp_err = exp_err | (qf != v) | (qbf != ~v);
    q0.push_back('{val: v, dcyc: cyc + 1 + P0, err: exp_err});
    for (int unsigned k = 0; k <= P0 + G0; k++) begin
      @(negedge clk);
      chk("busy_during_cmd", {31'd0, busy}, 1);
      #1;
      req = poke && (k == 1 || k == P0 + 1);
      req_val = ~v;
    end
    @(negedge clk);
    chk("busy_after_cmd", {31'd0, busy}, 0);
    chk("level_after_cmd", {31'd0, level}, {31'd0, v});
    #1;
    req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req = 1'b1; req_val = 1'b1; q_fb = 1'b0; q_bar_fb = 1'b1;
    req1 = 1'b0; req_val1 = 1'b0; q_fb1 = 1'b0; q_bar_fb1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_s", {31'd0, s}, 0);
    chk("rst_r", {31'd0, r}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_level", {31'd0, level}, 0);
    #1;
    reset = 1'b0;
    req = 1'b0;

    run_cmd(1'b1, 1'b1, 1'b0, 1'b0);
    run_cmd(1'b0, 1'b0, 1'b1, 1'b0);
    run_cmd(1'b1, 1'b0, 1'b1, 1'b0);
    run_cmd(1'b0, 1'b0, 1'b1, 1'b0);
    run_cmd(1'b1, 1'b1, 1'b0, 1'b1);
    chk("err_sticky", {31'd0, err}, 1);

    // Reset in the second PULSE cycle, then a fresh command right after
    @(negedge clk); #1;
    req = 1'b1; req_val = 1'b1; q_fb = 1'b1; q_bar_fb = 1'b0;
    @(negedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("midop_s_high", {31'd0, s}, 1);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midop_s", {31'd0, s}, 0);
    chk("midop_r", {31'd0, r}, 0);
    chk("midop_busy", {31'd0, busy}, 0);
    chk("midop_done", {31'd0, done}, 0);
    chk("midop_err", {31'd0, err}, 0);
    chk("midop_level", {31'd0, level}, 0);
    #1;
    reset = 1'b0;
    exp_err = 1'b0;
    req = 1'b1; req_val = 1'b0; q_fb = 1'b0; q_bar_fb = 1'b1;
    q0.push_back('{val: 1'b0, dcyc: cyc + 1 + P0, err: 1'b0});
    @(negedge clk);
    chk("fresh_busy", {31'd0, busy}, 1);
    #1;
    req = 1'b0;
    repeat (P0 + G0 + 2) @(negedge clk);

    run_cmd(1'b0, 1'b0, 1'b1, 1'b0);
    drain();

    for (int unsigned k = 0; k < 12; k++) begin
      @(negedge clk);
      #1;
      req1 = 1'b1;
      req_val1 = k[0];
      if (k % 3 == 0) begin
        q_fb1 = k[0];
        q_bar_fb1 = ~k[0];
        q1.push_back('{val: k[0], dcyc: cyc + 2, err: 1'b0});
      end
    end
    @(negedge clk);
    #1;
    req1 = 1'b0;
    drain();
    chk("final_err1", {31'd0, err1}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 Parameter PULSE_CYCLES, default 2: cycles s/r held high per command; legal range 1..15.
REQ-002 Parameter GAP_CYCLES, default 1: idle cycles after check before next command accepted; legal range 0..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  1  command strobe; sampled only in IDLE.
REQ-006 req_val  input  1  requested latch level (1 = set, 0 = reset), captured with req.
REQ-007 q_fb  input  1  latch q feedback.
REQ-008 q_bar_fb  input  1  latch q_bar feedback.
REQ-009 s  output  1  set drive to latch, registered.
REQ-010 r  output  1  reset drive to latch, registered.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 done  output  1  one-cycle pulse marking command completion.
REQ-013 err  output  1  sticky feedback-mismatch flag.
REQ-014 level  output  1  last commanded level, updated at acceptance.

Function
REQ-015 States SHALL be IDLE, PULSE, CHECK, GAP; a 4-bit down-counter SHALL time PULSE and GAP.
REQ-016 In IDLE with req=1, the next edge SHALL latch req_val into level, load counter with PULSE_CYCLES-1 and enter PULSE.
REQ-017 req in any state other than IDLE SHALL be ignored, with no queuing.
REQ-018 In PULSE, s SHALL equal level and r SHALL equal ~level for exactly PULSE_CYCLES cycles; on counter=0 the state SHALL go to CHECK.
REQ-019 s and r SHALL never be 1 in the same cycle under any input or reset sequence.
REQ-020 In CHECK, s=r=0 and done=1 for exactly one cycle.
REQ-021 In CHECK, if q_fb!=level or q_bar_fb!=~level, err SHALL be set at the next edge and held until reset.
REQ-022 After CHECK, the block SHALL go to GAP with counter=GAP_CYCLES-1 if GAP_CYCLES>0, else directly to IDLE.
REQ-023 In GAP, s=r=0; on counter=0 the state SHALL go to IDLE.
REQ-024 Latency: req sampled at edge N puts s/r high in cycles N+1..N+PULSE_CYCLES and done in cycle N+PULSE_CYCLES+1.
REQ-025 IDLE SHALL be re-entered at cycle N+PULSE_CYCLES+GAP_CYCLES+2.
REQ-026 busy SHALL be high from cycle N+1 through the last GAP cycle inclusive.
REQ-027 Back-to-back: req held high continuously SHALL issue a new command on each IDLE cycle, using req_val as sampled at that cycle.
REQ-028 A command equal to the current level SHALL still issue a full pulse and check sequence.
REQ-029 Feedback inputs SHALL be ignored outside CHECK.

Reset
REQ-030 reset=1 at an edge SHALL force state=IDLE, counter=0, s=0, r=0, busy=0, done=0, err=0 and level=0.
REQ-031 Reset SHALL override req sampled in the same cycle.
REQ-032 Reset during PULSE SHALL drop s/r at that edge, with no done and no err update.
REQ-033 On the first cycle after reset deassertion, the block SHALL accept req.

Verification
REQ-034 Set command with defaults (P=2, G=1). Stimulus: req=1, req_val=1 at edge 0, feedback q_fb=1, q_bar_fb=0. Response: s=1 in cycles 1-2; done=1 in cycle 3; busy low in cycle 5; err=0; level=1.
REQ-035 Reset command. Stimulus: req_val=0, feedback q_fb=0, q_bar_fb=1. Response: r=1 for 2 cycles; s stays 0; done once; err=0; level=0.
REQ-036 Mismatch. Stimulus: set command with q_fb held 0 during CHECK. Response: err=1 from the cycle after CHECK; err persists through later good commands until reset.
REQ-037 Busy rejection. Stimulus: req pulsed during PULSE and during GAP. Response: no additional pulse; exactly one done.
REQ-038 Mid-operation reset. Stimulus: reset asserted in the second PULSE cycle. Response: all outputs 0 at the next cycle; a req the following cycle starts a fresh command.
REQ-039 Parameter corners. Stimulus: P=1, G=0 with req held high and req_val alternating. Response: a command every 3 cycles; s/r never simultaneously 1 (checked every cycle).
